// File: rtl/fetch_stage.sv
// XM23 instruction fetch stage: PC, single-outstanding imem read port and a small
// instruction FIFO feeding decode, with stall back-pressure and redirect flush.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_valid
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
  localparam logic [15:0] ResetPcAligned = {RESET_PC[15:1], 1'b0};

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDiscard
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     req_pc_q, req_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] count_next;

  logic [15:0] pc_mem_q   [FIFO_DEPTH];
  logic [15:0] data_mem_q [FIFO_DEPTH];

  logic empty, resp, push, pop, issue;

  // Output side and issue decision; imem_req is combinational from rvalid/stall.
  always_comb begin
    empty      = (count_q == '0);
    inst_valid = !empty && !redirect_valid;
    inst       = empty ? 16'h0000 : data_mem_q[rd_ptr_q];
    inst_pc    = empty ? 16'h0000 : pc_mem_q[rd_ptr_q];
    pop        = inst_valid && !stall;
    resp       = (state_q == StBusy) && imem_rvalid;
    push       = resp && !redirect_valid;
    count_next = count_q + CntW'(push) - CntW'(pop);
    issue      = !reset && !redirect_valid &&
                 ((state_q == StIdle) || resp) && (count_next < DepthC);
    imem_req   = issue;
    imem_addr  = pc_q;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_next;

    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = redirect_pc & 16'hFFFE;
      // An in-flight request that has not answered yet must be dropped later.
      case (state_q)
        StBusy:    state_d = imem_rvalid ? StIdle : StDiscard;
        StDiscard: state_d = imem_rvalid ? StIdle : StDiscard;
        default:   state_d = StIdle;
      endcase
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case (state_q)
        StBusy:    if (imem_rvalid) state_d = StIdle;
        StDiscard: if (imem_rvalid) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
      if (issue) begin
        state_d  = StBusy;
        pc_d     = pc_q + 16'd2;
        req_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= ResetPcAligned;
      req_pc_q <= ResetPcAligned;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says so.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
      data_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner-case sequences and a random
// run checked against a queue-based reference model with a variable-latency memory.
module tb_fetch_stage;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] inst, inst_pc;
  logic        inst_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Memory environment: one outstanding read, latency drawn per request.
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_addr_q;
  int          lat_min = 1, lat_max = 1;
  logic [15:0] data_off = 16'h4008;
  bit          spurious_en = 1'b0;

  // Reference model: FIFO as a queue, plus outstanding/drop flags.
  typedef struct packed {logic [15:0] pc; logic [15:0] data;} entry_t;
  entry_t      m_q[$];
  logic [15:0] m_pc, m_req_pc;
  bit          m_out, m_drop;

  logic        o_req, o_valid;
  logic [15:0] o_addr, o_pc, o_inst;

  bit          seq_en = 1'b0;
  bit          seq_have = 1'b0;
  logic [15:0] seq_last;

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return a + data_off;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not seen within bound (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc     = {RESET_PC[15:1], 1'b0};
    m_req_pc = m_pc;
    m_out    = 1'b0;
    m_drop   = 1'b0;
    mem_busy = 1'b0;
  endtask

  // One clock cycle: caller has set stall/redirect at the negedge.
  task automatic tick();
    logic e_valid, e_req, pop, resp, push;
    logic [15:0] e_inst, e_pc;
    int occ;
    if (mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(mem_addr_q);
    end else if (spurious_en && $urandom_range(9) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'($urandom);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    #1;
    e_valid = (m_q.size() > 0) && !redirect_valid;
    e_inst  = (m_q.size() > 0) ? m_q[0].data : 16'h0000;
    e_pc    = (m_q.size() > 0) ? m_q[0].pc : 16'h0000;
    pop     = e_valid && !stall;
    resp    = m_out && imem_rvalid;
    push    = resp && !m_drop && !redirect_valid;
    occ     = m_q.size() + int'(push) - int'(pop);
    e_req   = !redirect_valid && (!m_out || (resp && !m_drop)) && (occ < DEPTH);

    o_req = imem_req; o_addr = imem_addr; o_valid = inst_valid; o_pc = inst_pc; o_inst = inst;
    chk("imem_req", 16'(o_req), 16'(e_req));
    chk("imem_addr", o_addr, m_pc);
    chk("inst_valid", 16'(o_valid), 16'(e_valid));
    chk("inst", o_inst, e_inst);
    chk("inst_pc", o_pc, e_pc);
    if (seq_en && o_valid && !stall) begin
      if (seq_have) chk("seq_inst_pc", o_pc, seq_last + 16'd2);
      seq_last = o_pc;
      seq_have = 1'b1;
    end

    @(posedge clk);
    if (mem_busy) begin
      if (mem_cnt == 0) mem_busy = 1'b0;
      else mem_cnt--;
    end
    if (o_req) begin
      mem_busy   = 1'b1;
      mem_cnt    = int'($urandom_range(lat_max, lat_min)) - 1;
      mem_addr_q = o_addr;
    end
    if (redirect_valid) begin
      m_q.delete();
      m_pc = redirect_pc & 16'hFFFE;
      if (m_out) begin
        if (resp) m_out = 1'b0;
        else m_drop = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({m_req_pc, imem_rdata});
      if (resp) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if (e_req) begin
        m_out    = 1'b1;
        m_drop   = 1'b0;
        m_req_pc = m_pc;
        m_pc     = m_pc + 16'd2;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    imem_rvalid = 1'b0;
    seq_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", 16'(imem_req), 16'h0000);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_inst_valid", 16'(inst_valid), 16'h0000);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] inst;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit found, found2;
    logic [15:0] first_addr, first_pc, second_addr, second_pc;

    vecs[0] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h4008};
    vecs[3] = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h0002, 16'h400A};
    vecs[4] = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0004, 16'h400C};

    // Streaming with a 1-cycle memory.
    data_off = 16'h4008; lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      stall = vecs[i].stall;
      tick();
      chk("t1_req", 16'(o_req), 16'(vecs[i].req));
      chk("t1_addr", o_addr, vecs[i].addr);
      chk("t1_valid", 16'(o_valid), 16'(vecs[i].valid));
      chk("t1_pc", o_pc, vecs[i].pc);
      chk("t1_inst", o_inst, vecs[i].inst);
    end

    // Stall mid-stream: FIFO fills, requests stop, then resume in order.
    seq_en = 1'b1; seq_have = 1'b1; seq_last = 16'h0004;
    stall = 1'b0; repeat (2) tick();
    stall = 1'b1; repeat (6) tick();
    chk("t2_req_dropped", 16'(o_req), 16'h0000);
    chk("t2_valid_held", 16'(o_valid), 16'h0001);
    stall = 1'b0; repeat (8) tick();
    seq_en = 1'b0;

    // Redirect one cycle after the request to 0006 with 3-cycle memory.
    data_off = 16'($urandom); lat_min = 3; lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (o_req && o_addr == 16'h0006) found = 1'b1;
    end
    if (!found) fail_now("t3_req_0006");
    redirect_valid = 1'b1; redirect_pc = 16'h0101;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0; found2 = 1'b0;
    for (int i = 0; i < 40 && !found2; i++) begin
      tick();
      if (o_req && !found) begin found = 1'b1; first_addr = o_addr; end
      if (o_valid && !found2) begin found2 = 1'b1; first_pc = o_pc; end
    end
    if (found) chk("t3_next_addr", first_addr, 16'h0100); else fail_now("t3_next_addr");
    if (found2) chk("t3_first_pc", first_pc, 16'h0100); else fail_now("t3_first_pc");

    // Redirect to the top of memory: address wraps to 0000.
    lat_min = 1; lat_max = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0; found2 = 1'b0;
    first_addr = 16'h1111; second_addr = 16'h1111; first_pc = 16'h1111; second_pc = 16'h1111;
    for (int i = 0, na = 0, np = 0; i < 20 && (na < 2 || np < 2); i++) begin
      tick();
      if (o_req) begin
        if (na == 0) first_addr = o_addr; else if (na == 1) second_addr = o_addr;
        na++;
      end
      if (o_valid) begin
        if (np == 0) first_pc = o_pc; else if (np == 1) second_pc = o_pc;
        np++;
      end
    end
    chk("t4_addr0", first_addr, 16'hFFFE);
    chk("t4_addr1", second_addr, 16'h0000);
    chk("t4_pc0", first_pc, 16'hFFFE);
    chk("t4_pc1", second_pc, 16'h0000);

    // Redirect + stall + rvalid together with one FIFO entry.
    do_reset();
    tick(); tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick();
    chk("t5_valid_redirect", 16'(o_valid), 16'h0000);
    chk("t5_req_redirect", 16'(o_req), 16'h0000);
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    chk("t5_valid_after", 16'(o_valid), 16'h0000);
    chk("t5_req_after", 16'(o_req), 16'h0001);
    chk("t5_addr_after", o_addr, 16'h0200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (o_valid) begin found = 1'b1; first_pc = o_pc; end
    end
    if (found) chk("t5_first_pc", first_pc, 16'h0200); else fail_now("t5_first_pc");

    // Asynchronous reset while a request is outstanding and the FIFO holds data.
    do_reset();
    repeat (4) tick();
    chk("t6_pre_valid", 16'(inst_valid), 16'h0001);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 16'(inst_valid), 16'h0000);
    chk("t6_async_req", 16'(imem_req), 16'h0000);
    chk("t6_async_inst", inst, 16'h0000);
    chk("t6_async_pc", inst_pc, 16'h0000);
    imem_rvalid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("t6_first_req", 16'(o_req), 16'h0001);
    chk("t6_first_addr", o_addr, RESET_PC);

    // Random traffic against the reference model.
    lat_min = 1; lat_max = 4; spurious_en = 1'b1; data_off = 16'($urandom);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(99) < 30);
      redirect_valid = ($urandom_range(99) < 5);
      redirect_pc = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3))
                                            : 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
